sram_arbiter_rr: RTL and testbench
==================================

# sram_arbiter_rr

Multi-channel arbiter for the board's external asynchronous SRAM. Up to `nch` user channels share one SRAM PHY. Grants rotate round-robin, and each channel gets a request/busy handshake and a per-channel read-valid strobe. Read access length is set by a parameter, and writes use a fixed two-cycle WE pulse/recovery slot. It sits between the user logic (audio buffers, DMA) and the top-level tristate SRAM pins.

## Interface
Parameters:
- `nch`, 2: number of user channels (≥1).
- `aw`, 19: SRAM address width.
- `dw`, 8: SRAM data width.
- `rd_cycles`, 1: cycles the read address is held before data capture (≥1).

Ports:
- `clk`  in  1  clock; the only clock in the block.
- `rst`  in  1  synchronous reset, active-high.
- `en`  in  1  global enable. When low, no new grants are issued; an in-flight slot still completes.
- `req`  in  nch  per-channel access request. Channel i holds its request until it is accepted.
- `we`  in  nch  per-channel write select (1 = write, 0 = read).
- `addr`  in  nch*aw  packed addresses; channel i uses bits [i*aw +: aw].
- `data_wr`  in  nch*dw  packed write data; channel i uses bits [i*dw +: dw].
- `busy`  out  nch  combinational; 0 only in the cycle that channel i's request is accepted.
- `data_rd`  out  dw  read data shared by all channels; qualified by `valid`.
- `valid`  out  nch  one-cycle read-done strobe for the owning channel.
- `sram_addr`  out  aw  registered SRAM address.
- `sram_ce_n`, `sram_oe_n`, `sram_we_n`  out  1 each  registered active-low SRAM controls.
- `sram_dat_wr`  out  dw  registered write data.
- `sram_dat_oe`  out  1  data-bus drive enable; the top level builds the tristate from it.
- `sram_dat_rd`  in  dw  SRAM data-bus input.

## Operation
- Handshake: channel i's request is accepted at a rising edge when `req[i]=1` and `busy[i]=0` in the preceding cycle. The channel must keep `addr`, `we` and `data_wr` stable until acceptance.
- Ready condition: the arbiter is ready when the state is IDLE, or when the current slot is in its final cycle. A grant issued in a final cycle starts the next slot back-to-back.
- Arbitration:
  - When ready and `en=1`, grant the first requesting channel, searching from `last+1` modulo `nch`.
  - `last` is then updated to the granted channel.
  - `last` resets to `nch-1`, so channel 0 wins first.
  - Exactly one grant per ready cycle; `busy[j]=1` for every j that is not granted.
- States:
  - IDLE: no slot in progress.
  - READ: `rd_cycles` cycles.
  - WR_PULSE: 1 cycle.
  - WR_HOLD: 1 cycle.
- Transitions:
  - A grant moves the state to READ or WR_PULSE according to `we[i]`.
  - READ leaves on its final cycle.
  - WR_PULSE always goes to WR_HOLD.
  - WR_HOLD leaves immediately.
  - On leaving READ or WR_HOLD, go to the next slot if a grant occurs, otherwise to IDLE.
- Latched at grant: address, data, write select and owner index.
- PHY outputs:
  - READ: `ce_n=0`, `oe_n=0`, `we_n=1`, `dat_oe=0`.
  - WR_PULSE: `ce_n=0`, `oe_n=1`, `we_n=0`, `dat_oe=1`.
  - WR_HOLD: `ce_n=0`, `oe_n=1`, `we_n=1`, `dat_oe=1`; address and data held.
  - IDLE: `ce_n=1`, `oe_n=1`, `we_n=1`, `dat_oe=0`; address and data keep their last values.
- Read completion: at the edge ending the last READ cycle, `data_rd` ← `sram_dat_rd` and `valid[owner]` ← 1 for one cycle. `data_rd` holds until the next capture.
- Writes produce no `valid` strobe.
- Read cycle counter is ⌈log2(rd_cycles+1)⌉ bits and loads to `rd_cycles-1` on entry to READ.

## Timing
- Accept at the end of cycle N:
  - Read: PHY active for cycles N+1 … N+`rd_cycles`; `valid`/`data_rd` in cycle N+`rd_cycles`+1.
  - Write: WE low in cycle N+1, hold in cycle N+2; the next slot starts no earlier than N+3.
- Throughput: one read per `rd_cycles` cycles; one write per 2 cycles.
- Reset values: `busy`=all ones, `valid`=0, `data_rd`=0, `sram_addr`=0, `sram_dat_wr`=0, `sram_ce_n`=1, `sram_oe_n`=1, `sram_we_n`=1, `sram_dat_oe`=0, state=IDLE, `last`=`nch-1`.
- Reset mid-slot: the slot is aborted and PHY controls are inactive from the next cycle. An aborted read produces no `valid`.
- `en` falling mid-slot: the slot completes normally, then the state goes to IDLE. While `en=0`, `busy`=all ones.
- `req` deasserted before acceptance: the request is withdrawn with no side effect.

## Test plan
- Single read, `rd_cycles`=1: ch0 reads 0x12345, SRAM model returns 0xA5 → `sram_addr`=0x12345 with `oe_n=0` one cycle after accept; `valid[0]`=1 with `data_rd`=0xA5 two cycles after accept.
- Single write: ch1 writes 0x3C to 0x00010 → `we_n` low for exactly 1 cycle; `dat_oe`=1 for 2 cycles; `sram_dat_wr`=0x3C and address stable across both cycles; no `valid`.
- Contention: ch0 and ch1 request reads simultaneously from reset → ch0 accepted first and ch1 in the next ready cycle; `valid[0]` then `valid[1]` on consecutive cycles (`rd_cycles`=1).
- Fairness, `nch`=3, `rd_cycles`=2: all channels request continuously → grant order 0,1,2,0,1,2; every grant exactly 2 cycles apart.
- `en`=0 with pending requests → `busy` all ones and `ce_n`=1. Raising `en` → grant within 1 cycle.
- `rst` asserted during WR_PULSE → `we_n`=1 the next cycle, all outputs at reset values, first post-reset grant goes to ch0.

Source files
------------

// File: rtl/sram_arbiter_rr_if.sv
// Purpose: user-channel handshake bundle plus SRAM PHY signals for sram_arbiter_rr.
// Latency: none; this is wiring only.
// Backpressure: per-channel busy; a request is held until busy drops for one cycle.
// Ports: slave = arbiter side, master = user logic / pin side.
//   en, req, we, addr, data_wr        user requests into the arbiter
//   busy, data_rd, valid              handshake and read return to the users
//   sram_addr, sram_*_n, sram_dat_*   SRAM PHY pins (sram_dat_rd is the only PHY input)
interface sram_arbiter_rr_if #(
   parameter int nch = 2,
   parameter int aw  = 19,
   parameter int dw  = 8
);
   logic                en;
   logic [nch-1:0]      req;
   logic [nch-1:0]      we;
   logic [nch*aw-1:0]   addr;
   logic [nch*dw-1:0]   data_wr;
   logic [nch-1:0]      busy;
   logic [dw-1:0]       data_rd;
   logic [nch-1:0]      valid;
   logic [aw-1:0]       sram_addr;
   logic                sram_ce_n;
   logic                sram_oe_n;
   logic                sram_we_n;
   logic [dw-1:0]       sram_dat_wr;
   logic                sram_dat_oe;
   logic [dw-1:0]       sram_dat_rd;

   modport slave (
      input  en, req, we, addr, data_wr, sram_dat_rd,
      output busy, data_rd, valid,
      output sram_addr, sram_ce_n, sram_oe_n, sram_we_n, sram_dat_wr, sram_dat_oe
   );

   modport master (
      output en, req, we, addr, data_wr, sram_dat_rd,
      input  busy, data_rd, valid,
      input  sram_addr, sram_ce_n, sram_oe_n, sram_we_n, sram_dat_wr, sram_dat_oe
   );
endinterface

// File: rtl/sram_arbiter_rr.sv
// Purpose: round-robin arbiter sharing one asynchronous SRAM PHY between nch channels.
// Latency: PHY active one cycle after accept; read data/valid rd_cycles+1 cycles after accept.
// Backpressure: busy[i] drops for the single accepting cycle; requests wait while busy or en=0.
// Ports: clk, rst (sync, active-high); bus (slave modport) carries the channel handshake
//   (en, req, we, addr, data_wr, busy, data_rd, valid) and the SRAM pins (sram_*).
module sram_arbiter_rr #(
   parameter int nch       = 2,
   parameter int aw        = 19,
   parameter int dw        = 8,
   parameter int rd_cycles = 1
) (
   input logic              clk,
   input logic              rst,
   sram_arbiter_rr_if.slave bus
);
   localparam int lw = (nch > 1) ? $clog2(nch) : 1;
   localparam int cw = $clog2(rd_cycles + 1);

   typedef enum logic [1:0] {IDLE, READ, WR_PULSE, WR_HOLD} state_t;

   state_t          state, state_nxt;
   logic [cw-1:0]   rd_cnt, rd_cnt_nxt;
   logic [lw-1:0]   last;
   logic [lw-1:0]   owner;
   logic            gnt_vld;
   logic [lw-1:0]   gnt_idx;
   logic            rd_done;
   logic            ready;
   logic            accept;
   logic [nch-1:0]  busy_c;
   logic            ce_n_nxt, oe_n_nxt, we_n_nxt, dat_oe_nxt;

   // A read slot ends when its counter reaches zero; a write slot ends in WR_HOLD.
   assign rd_done = (state == READ) && (rd_cnt == '0);
   assign ready   = (state == IDLE) || rd_done || (state == WR_HOLD);
   assign accept  = ready && bus.en && gnt_vld && !rst;

   // Search starts just after the previous winner so every channel gets a turn.
   always_comb begin
      int c;
      gnt_vld = 1'b0;
      gnt_idx = '0;
      c       = 0;
      for (int k = 1; k <= nch; k++) begin
         c = (int'(last) + k) % nch;
         if (!gnt_vld && bus.req[c[lw-1:0]]) begin
            gnt_vld = 1'b1;
            gnt_idx = c[lw-1:0];
         end
      end
   end

   always_comb begin
      busy_c = '1;
      if (accept) busy_c[gnt_idx] = 1'b0;
   end
   assign bus.busy = busy_c;

   // Next-state logic; a grant in a slot's final cycle chains the next slot directly.
   always_comb begin
      state_nxt  = state;
      rd_cnt_nxt = rd_cnt;
      case (state)
         READ: begin
            if (rd_cnt != '0) rd_cnt_nxt = rd_cnt - 1'b1;
            else              state_nxt  = IDLE;
         end
         WR_PULSE: state_nxt = WR_HOLD;
         WR_HOLD:  state_nxt = IDLE;
         default:  state_nxt = IDLE;
      endcase
      if (accept) begin
         state_nxt  = bus.we[gnt_idx] ? WR_PULSE : READ;
         rd_cnt_nxt = cw'(rd_cycles - 1);
      end
   end

   // PHY controls are decoded from the next state so the pins register alongside it.
   always_comb begin
      ce_n_nxt   = 1'b1;
      oe_n_nxt   = 1'b1;
      we_n_nxt   = 1'b1;
      dat_oe_nxt = 1'b0;
      case (state_nxt)
         READ: begin
            ce_n_nxt = 1'b0;
            oe_n_nxt = 1'b0;
         end
         WR_PULSE: begin
            ce_n_nxt   = 1'b0;
            we_n_nxt   = 1'b0;
            dat_oe_nxt = 1'b1;
         end
         WR_HOLD: begin
            ce_n_nxt   = 1'b0;
            dat_oe_nxt = 1'b1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state           <= IDLE;
         rd_cnt          <= '0;
         last            <= lw'(nch - 1);
         owner           <= '0;
         bus.valid       <= '0;
         bus.data_rd     <= '0;
         bus.sram_addr   <= '0;
         bus.sram_dat_wr <= '0;
         bus.sram_ce_n   <= 1'b1;
         bus.sram_oe_n   <= 1'b1;
         bus.sram_we_n   <= 1'b1;
         bus.sram_dat_oe <= 1'b0;
      end else begin
         state           <= state_nxt;
         rd_cnt          <= rd_cnt_nxt;
         bus.sram_ce_n   <= ce_n_nxt;
         bus.sram_oe_n   <= oe_n_nxt;
         bus.sram_we_n   <= we_n_nxt;
         bus.sram_dat_oe <= dat_oe_nxt;
         bus.valid       <= '0;
         // Capture uses the owner of the finishing slot, before a chained grant replaces it.
         if (rd_done) begin
            bus.data_rd      <= bus.sram_dat_rd;
            bus.valid[owner] <= 1'b1;
         end
         if (accept) begin
            last            <= gnt_idx;
            owner           <= gnt_idx;
            bus.sram_addr   <= bus.addr[int'(gnt_idx)*aw +: aw];
            bus.sram_dat_wr <= bus.data_wr[int'(gnt_idx)*dw +: dw];
         end
      end
   end
endmodule

// File: tb/tb_sram_arbiter_rr.sv
// Purpose: self-checking bench for sram_arbiter_rr (nch=3, rd_cycles=2) against a slot-schedule model.
// Latency: model predicts PHY activity, valid timing and busy for every cycle.
// Backpressure: channels hold requests until the model sees them accepted.
module tb_sram_arbiter_rr;
   localparam int NCH = 3;
   localparam int AW  = 19;
   localparam int DW  = 8;
   localparam int RDC = 2;

   logic clk;
   logic rst;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   sram_arbiter_rr_if #(.nch(NCH), .aw(AW), .dw(DW)) bus();

   sram_arbiter_rr #(.nch(NCH), .aw(AW), .dw(DW), .rd_cycles(RDC)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   // SRAM contents are a fixed function of the address; drive only while OE is active.
   function automatic logic [DW-1:0] sram_val(input logic [AW-1:0] a);
      return a[7:0] ^ a[15:8] ^ {5'b0, a[18:16]} ^ 8'h5A;
   endfunction
   assign bus.sram_dat_rd = bus.sram_oe_n ? '0 : sram_val(bus.sram_addr);

   int n_chk = 0;
   int n_err = 0;
   int cyc   = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at cycle %0d", tag, got, exp, cyc);
      end
   endtask

   // Channel-side stimulus state
   logic [NCH-1:0] ch_act;
   logic [NCH-1:0] ch_we;
   logic [AW-1:0]  ch_addr [NCH];
   logic [DW-1:0]  ch_dat  [NCH];
   logic           rst_v, en_v;
   bit             rand_mode, cont_mode;

   // Reference model: the current slot as a cycle window, plus pending read returns
   bit            m_vld;
   int            m_start, m_len, m_last;
   bit            m_we;
   logic [AW-1:0] m_addr;
   logic [DW-1:0] m_wdat, m_rdat;
   typedef struct {int due; int ch; logic [DW-1:0] dat;} rd_t;
   rd_t rdq[$];
   typedef struct {int cyc; int ch;} gl_t;
   gl_t glog[$];   // grants observed on the DUT's busy outputs

   task automatic model_reset();
      m_vld   = 1'b0;
      m_start = 0;
      m_len   = 0;
      m_we    = 1'b0;
      m_last  = NCH - 1;
      m_addr  = '0;
      m_wdat  = '0;
      m_rdat  = '0;
      rdq.delete();
   endtask

   task automatic set_req(input int i, input bit w, input logic [AW-1:0] a, input logic [DW-1:0] d);
      ch_act[i]  = 1'b1;
      ch_we[i]   = w;
      ch_addr[i] = a;
      ch_dat[i]  = d;
   endtask

   task automatic drive();
      @(posedge clk);
      #1;
      if (rand_mode) begin
         rst_v = ($urandom_range(0, 149) == 0);
         en_v  = ($urandom_range(0, 7) != 0);
         for (int i = 0; i < NCH; i++) begin
            if (!ch_act[i] && $urandom_range(0, 2) == 0)
               set_req(i, 1'($urandom_range(0, 1)), AW'($urandom), DW'($urandom));
            else if (ch_act[i] && $urandom_range(0, 19) == 0)
               ch_act[i] = 1'b0;
         end
      end
      if (cont_mode)
         for (int i = 0; i < NCH; i++)
            if (!ch_act[i]) set_req(i, 1'b0, AW'($urandom), DW'($urandom));
      rst     = rst_v;
      bus.en  = en_v;
      bus.req = ch_act;
      bus.we  = ch_we;
      for (int i = 0; i < NCH; i++) begin
         bus.addr[i*AW +: AW]    = ch_addr[i];
         bus.data_wr[i*DW +: DW] = ch_dat[i];
      end
   endtask

   task automatic check_cycle();
      logic [NCH-1:0] exp_busy, exp_valid;
      bit act, ready;
      int g;
      @(negedge clk);
      for (int i = 0; i < NCH; i++)
         if (bus.busy[i] === 1'b0) glog.push_back('{cyc, i});
      act = m_vld && (cyc >= m_start) && (cyc < m_start + m_len);
      chk("ce_n",        bus.sram_ce_n,   !act);
      chk("oe_n",        bus.sram_oe_n,   !(act && !m_we));
      chk("we_n",        bus.sram_we_n,   !(act && m_we && cyc == m_start));
      chk("dat_oe",      bus.sram_dat_oe, act && m_we);
      chk("sram_addr",   bus.sram_addr,   m_addr);
      chk("sram_dat_wr", bus.sram_dat_wr, m_wdat);
      exp_valid = '0;
      if (rdq.size() > 0 && rdq[0].due == cyc) begin
         exp_valid = NCH'(1) << rdq[0].ch;
         m_rdat    = rdq[0].dat;
         void'(rdq.pop_front());
      end
      chk("valid",   bus.valid,   exp_valid);
      chk("data_rd", bus.data_rd, m_rdat);
      ready = !rst && (!m_vld || cyc >= m_start + m_len - 1);
      g = -1;
      if (ready && bus.en)
         for (int k = 1; k <= NCH; k++) begin
            int c;
            c = (m_last + k) % NCH;
            if (g < 0 && bus.req[c]) g = c;
         end
      exp_busy = '1;
      if (g >= 0) exp_busy = ~(NCH'(1) << g);
      chk("busy", bus.busy, exp_busy);
      if (rst) begin
         model_reset();
      end else if (g >= 0) begin
         m_vld   = 1'b1;
         m_start = cyc + 1;
         m_we    = bus.we[g];
         m_len   = m_we ? 2 : RDC;
         m_last  = g;
         m_addr  = bus.addr[g*AW +: AW];
         m_wdat  = bus.data_wr[g*DW +: DW];
         if (!m_we) rdq.push_back('{cyc + RDC + 1, g, sram_val(m_addr)});
         ch_act[g] = 1'b0;
      end
      cyc++;
   endtask

   task automatic run(input int n);
      repeat (n) begin
         drive();
         check_cycle();
      end
   endtask

   initial begin
      int nf;
      rst = 1'b1;
      bus.en = 1'b1;
      bus.req = '0;
      bus.we = '0;
      bus.addr = '0;
      bus.data_wr = '0;
      ch_act = '0;
      ch_we = '0;
      for (int i = 0; i < NCH; i++) begin
         ch_addr[i] = '0;
         ch_dat[i]  = '0;
      end
      rst_v = 1'b1;
      en_v = 1'b1;
      rand_mode = 1'b0;
      cont_mode = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);

      // Reset values held while rst is asserted
      run(3);
      rst_v = 1'b0;
      run(2);

      // Single read, single write, then simultaneous reads
      set_req(0, 1'b0, 19'h12345, 8'h00);
      run(6);
      set_req(1, 1'b1, 19'h00010, 8'h3C);
      run(6);
      set_req(0, 1'b0, 19'h00ABC, 8'h11);
      set_req(1, 1'b0, 19'h70F00, 8'h22);
      run(8);

      // Fairness from a fresh reset: all channels keep requesting
      rst_v = 1'b1;
      run(1);
      rst_v = 1'b0;
      glog.delete();
      cont_mode = 1'b1;
      run(13);
      cont_mode = 1'b0;
      ch_act = '0;
      run(6);
      chk("fair_count", glog.size() >= 6, 1);
      nf = (glog.size() < 6) ? glog.size() : 6;
      for (int i = 0; i < nf; i++) begin
         chk("fair_order", glog[i].ch, i % NCH);
         if (i > 0) chk("fair_gap", glog[i].cyc - glog[i-1].cyc, 2);
      end

      // Enable low with pending requests, then raised
      en_v = 1'b0;
      set_req(1, 1'b0, 19'h01234, 8'h00);
      set_req(2, 1'b1, 19'h05555, 8'hE7);
      run(5);
      en_v = 1'b1;
      run(8);

      // Reset during the write pulse; first grant afterwards must go to channel 0
      set_req(2, 1'b1, 19'h07ABC, 8'h99);
      run(1);
      rst_v = 1'b1;
      set_req(0, 1'b0, 19'h00042, 8'h00);
      set_req(1, 1'b0, 19'h00043, 8'h00);
      run(1);
      rst_v = 1'b0;
      glog.delete();
      run(7);
      chk("post_rst_gnt", (glog.size() > 0) ? glog[0].ch : -1, 0);

      // Randomized traffic with enable drops, withdrawals and occasional resets
      rand_mode = 1'b1;
      run(2000);
      rand_mode = 1'b0;
      rst_v = 1'b0;
      en_v = 1'b1;
      ch_act = '0;
      run(10);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
